// File: rtl/apb_master_param.sv
// apb_master_param
// Single-transfer APB master with parameterised address/data width, slave
// count and ACCESS-phase wait timeout. A request is accepted only while idle;
// the slave is chosen by the top SW address bits.
//
// Ports:
//   pclk, preset        clock and asynchronous active-high reset
//   new_data, wr, ain,  transfer request, direction, address and write data
//   din                 (latched together when the master is idle)
//   busy                high whenever a transfer is in progress
//   done, err           one-cycle completion pulse and its status
//   dout                data from the last successful read
//   paddr, psel,        APB request side (psel is one-hot over NSLV slaves)
//   penable, pwrite,
//   pwdata
//   prdata, pready,     APB response side, one slice/bit per slave
//   pslverr
module apb_master_param #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int NSLV    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               pclk,
  input  logic               preset,
  input  logic               new_data,
  input  logic               wr,
  input  logic [AW-1:0]      ain,
  input  logic [DW-1:0]      din,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [DW-1:0]      dout,
  output logic [AW-1:0]      paddr,
  output logic [NSLV-1:0]    psel,
  output logic               penable,
  output logic               pwrite,
  output logic [DW-1:0]      pwdata,
  input  logic [NSLV*DW-1:0] prdata,
  input  logic [NSLV-1:0]    pready,
  input  logic [NSLV-1:0]    pslverr
);

  localparam int SW = $clog2(NSLV);
  localparam int CW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [AW-1:0]     paddr_reg, paddr_next;
  logic [NSLV-1:0]   psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              pwrite_reg, pwrite_next;
  logic [DW-1:0]     pwdata_reg, pwdata_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic              busy_reg, busy_next;
  logic [DW-1:0]     dout_reg, dout_next;
  logic [CW-1:0]     cnt_reg, cnt_next;

  // Slave index of the incoming request and of the latched transfer.
  logic [SW-1:0]     idx_in;
  logic [SW-1:0]     idx;
  logic              sel_ready;
  logic              sel_err;
  logic [DW-1:0]     sel_rdata;
  logic [DW-1:0]     rdata_arr [NSLV];

  assign idx_in = ain[AW-1 -: SW];
  assign idx    = paddr_reg[AW-1 -: SW];

  genvar gi;
  generate
    for (gi = 0; gi < NSLV; gi++) begin : g_slice
      assign rdata_arr[gi] = prdata[gi*DW +: DW];
    end
  endgenerate

  // Only the addressed slave's response is ever looked at.
  assign sel_ready = pready[idx];
  assign sel_err   = pslverr[idx];
  assign sel_rdata = rdata_arr[idx];

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_reg   <= IDLE;
      paddr_reg   <= '0;
      psel_reg    <= '0;
      penable_reg <= 1'b0;
      pwrite_reg  <= 1'b0;
      pwdata_reg  <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      dout_reg    <= '0;
      cnt_reg     <= '0;
    end else begin
      state_reg   <= state_next;
      paddr_reg   <= paddr_next;
      psel_reg    <= psel_next;
      penable_reg <= penable_next;
      pwrite_reg  <= pwrite_next;
      pwdata_reg  <= pwdata_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
      busy_reg    <= busy_next;
      dout_reg    <= dout_next;
      cnt_reg     <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    paddr_next   = paddr_reg;
    psel_next    = psel_reg;
    penable_next = penable_reg;
    pwrite_next  = pwrite_reg;
    pwdata_next  = pwdata_reg;
    dout_next    = dout_reg;
    cnt_next     = cnt_reg;
    // done/err are pulses: they fall unless a completion happens this edge.
    done_next    = 1'b0;
    err_next     = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (new_data) begin
          paddr_next         = ain;
          pwrite_next        = wr;
          pwdata_next        = din;
          psel_next          = '0;
          psel_next[idx_in]  = 1'b1;
          penable_next       = 1'b0;
          state_next         = SETUP;
        end
      end
      SETUP: begin
        penable_next = 1'b1;
        cnt_next     = '0;
        state_next   = ACCESS;
      end
      ACCESS: begin
        // A ready response wins over a timeout reached in the same cycle.
        if (sel_ready) begin
          state_next   = IDLE;
          psel_next    = '0;
          penable_next = 1'b0;
          done_next    = 1'b1;
          err_next     = sel_err;
          if (!pwrite_reg && !sel_err) begin
            dout_next = sel_rdata;
          end
        end else if (cnt_reg == CW'(TIMEOUT)) begin
          state_next   = IDLE;
          psel_next    = '0;
          penable_next = 1'b0;
          done_next    = 1'b1;
          err_next     = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        psel_next    = '0;
        penable_next = 1'b0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;
  assign dout    = dout_reg;
  assign paddr   = paddr_reg;
  assign psel    = psel_reg;
  assign penable = penable_reg;
  assign pwrite  = pwrite_reg;
  assign pwdata  = pwdata_reg;

endmodule

// File: doc/apb_master_param.md
APB_MASTER_PARAM -- requirements
Module: apb_master_param

Interface
REQ-001 Parameter AW, default 8: address width, in bits.
REQ-002 Parameter DW, default 8: data width, in bits.
REQ-003 Parameter NSLV, default 4: number of slaves; power of two, 2 or more; SW = log2(NSLV).
REQ-004 Parameter TIMEOUT, default 15: maximum number of ACCESS cycles with pready low; range 1 to 255.
REQ-005 pclk  in  1  single clock; all state updates on the rising edge.
REQ-006 preset  in  1  asynchronous, active-high reset.
REQ-007 new_data  in  1  transfer request, sampled only in IDLE.
REQ-008 wr  in  1  1 = write, 0 = read; latched with new_data.
REQ-009 ain  in  AW  transfer address; latched with new_data.
REQ-010 din  in  DW  write data; latched with new_data.
REQ-011 busy  out  1  high whenever the state is not IDLE.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 err  out  1  completion status, valid while done is high.
REQ-014 dout  out  DW  last successful read data.
REQ-015 paddr  out  AW  APB address.
REQ-016 psel  out  NSLV  one-hot slave select.
REQ-017 penable  out  1  APB enable.
REQ-018 pwrite  out  1  APB direction.
REQ-019 pwdata  out  DW  APB write data.
REQ-020 prdata  in  NSLV*DW  concatenated read data; slave k occupies bits [k*DW +: DW].
REQ-021 pready  in  NSLV  per-slave ready.
REQ-022 pslverr  in  NSLV  per-slave error.

Function
REQ-023 Slave index = latched address bits [AW-1 : AW-SW]; only that slave's pready, pslverr and prdata are examined.
REQ-024 The state machine has three states: IDLE, SETUP and ACCESS; all outputs are registered.
REQ-025 In IDLE, new_data=1 latches wr, ain and din and moves the state to SETUP; new_data=0 keeps the state in IDLE.
REQ-026 In SETUP, psel[index]=1, penable=0, paddr and pwrite and pwdata hold the latched values; the state moves unconditionally to ACCESS after one cycle.
REQ-027 In ACCESS, psel[index]=1 and penable=1; paddr, pwrite and pwdata stay stable until the transfer completes.
REQ-028 In ACCESS, pready[index]=1 completes the transfer at that edge: the state moves to IDLE, psel and penable go to 0, done=1 for one cycle, and err=pslverr[index].
REQ-029 On a read completion with pslverr[index]=0, dout is loaded from the selected prdata slice at the same edge; on a write completion, or on any completion with an error, dout holds its value.
REQ-030 The wait counter clears on entry to ACCESS and increments on every ACCESS cycle with pready[index]=0.
REQ-031 Timeout: when the wait counter equals TIMEOUT and pready[index]=0, the transfer aborts: the state moves to IDLE, psel and penable go to 0, done=1, err=1, and dout holds its value.
REQ-032 pready[index]=1 in the same cycle the counter reaches TIMEOUT counts as a normal completion, not a timeout.
REQ-033 new_data is ignored while busy=1; it is never queued.
REQ-034 Minimum transfer: new_data sampled at edge N gives done high after edge N+2; the earliest next SETUP follows edge N+3.
REQ-035 pready, pslverr and prdata of non-selected slaves have no effect.
REQ-036 err stays 0 whenever done=0.

Reset
REQ-037 When preset=1, the block enters IDLE immediately without waiting for a clock edge.
REQ-038 During reset, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, dout=0, done=0, err=0, busy=0, and the wait counter is 0.
REQ-039 Reset during SETUP or ACCESS abandons the transfer, and no done pulse follows.
REQ-040 The first new_data is sampled at the first rising edge after preset falls.

Verification
REQ-041 The bench shall cover this no-wait write: AW=8, DW=8, NSLV=4; wr=1, ain=0x45, din=0xA5, pready[1]=1 -> psel=0010 in SETUP and ACCESS, pwdata=0xA5, done 2 cycles after the request edge, err=0, dout=0x00.
REQ-042 The bench shall cover this wait-state read: wr=0, ain=0xC2, pready[3] low for 3 ACCESS cycles then high, prdata slice 3 = 0x3C -> psel=1000, done 5 cycles after the request edge, dout=0x3C, err=0.
REQ-043 The bench shall cover this timeout: ain=0x80, pready[2] held at 0 -> abort after 15 ACCESS wait cycles, done=1, err=1, psel=0, dout unchanged.
REQ-044 The bench shall cover this slave error: a read of ain=0x10 with pready[0]=1, pslverr[0]=1 and prdata slice 0 = 0xFF -> done=1, err=1, dout unchanged.
REQ-045 The bench shall cover this ignored request: new_data pulsed in the cycle after SETUP -> exactly one transfer and one done pulse.
REQ-046 The bench shall cover this mid-transfer reset: preset asserted in ACCESS cycle 2 of a waited read -> psel, penable and busy go to 0 with no clock edge, no done pulse, and dout=0x00.
